// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, requests words from instruction memory and
// holds each returned instruction for the decoder until it is retired.
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      op,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic            misalign_err,
    output logic [31:0]     instret
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_VALID
    } state_e;

    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            err_q, err_d;
    logic [31:0]     instret_q, instret_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        err_d     = err_q;
        instret_d = instret_q;
        unique case (state_q)
            S_FETCH, S_WAIT: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_VALID;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_VALID: begin
                if (instr_ready) begin
                    instret_d = instret_q + 32'd1;
                    state_d   = S_FETCH;
                    // Targets are force-aligned; a misaligned one is flagged.
                    if (pc_src) begin
                        pc_d = {pc_target[XLEN-1:2], 2'b00};
                        if (|pc_target[1:0]) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        pc_d = pc_q + XLEN'(4);
                    end
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= NOP;
            err_q     <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            err_q     <= err_d;
            instret_q <= instret_d;
        end
    end

    // Request is masked while reset is held so memory sees no stray fetch.
    assign imem_req     = rst_n & (state_q != S_VALID);
    assign imem_addr    = pc_q;
    assign instr        = instr_q;
    assign op           = instr_q[6:0];
    assign pc           = pc_q;
    assign pc_plus4     = pc_q + XLEN'(4);
    assign instr_valid  = (state_q == S_VALID);
    assign misalign_err = err_q;
    assign instret      = instret_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage that sits directly upstream of the main decoder.
- Holds the program counter and issues requests to instruction memory over a req/ack handshake.
- Latches the returned word and presents it, with its opcode field, to the decoder/execute logic until that logic retires it.
- Computes the next PC from PC+4 or the branch/jump target selected by the control path.

Parameters:
- XLEN, 32, width of PC, addresses and instruction word.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- imem_req  output  1  instruction memory request.
- imem_addr  output  XLEN  fetch address; always equals pc.
- imem_ack  input  1  memory has placed a valid word on imem_rdata this cycle.
- imem_rdata  input  XLEN  returned instruction word.
- instr  output  XLEN  latched instruction.
- op  output  7  instr[6:0], fed to the main decoder op input.
- pc  output  XLEN  address of instr.
- pc_plus4  output  XLEN  pc + 4, for the jal/jalr result source.
- instr_valid  output  1  instr/op/pc are valid.
- instr_ready  input  1  consumer retires the current instruction this cycle.
- pc_src  input  1  retire-cycle select: 1 = take pc_target, 0 = pc_plus4.
- pc_target  input  XLEN  branch/jump target.
- misalign_err  output  1  sticky flag: a target with bits [1:0] != 0 was taken.
- instret  output  32  count of retired instructions.

Behaviour:
- Reset (rst_n = 0 sampled at a clock edge):
  - pc = RESET_PC, instr = 32'h0000_0013 (nop), instr_valid = 0.
  - imem_req = 0, misalign_err = 0, instret = 0, state = FETCH.
- States:
  - FETCH: imem_req = 1. Move to VALID on imem_ack, otherwise to WAIT.
  - WAIT: imem_req held at 1 and imem_addr held stable until imem_ack. On ack, move to VALID.
  - VALID: imem_req = 0, instr_valid = 1, outputs held stable until instr_ready.
- Latch timing: on ack (in FETCH or WAIT), instr <= imem_rdata at that edge. instr_valid rises the following cycle.
- Ack in the same cycle as the request is legal. Minimum cost is 2 cycles per instruction: one FETCH cycle with ack, then one VALID cycle with ready.
- Retire: in VALID with instr_ready = 1:
  - pc <= pc_src ? pc_target : pc + 4, evaluated mod 2^XLEN, so 32'hFFFF_FFFC + 4 wraps to 0.
  - instret <= instret + 1, wrapping modulo 2^32.
  - state <= FETCH; instr_valid drops the next cycle.
- Ignored inputs:
  - instr_ready, pc_src and pc_target are ignored outside VALID.
  - imem_ack and imem_rdata are ignored in VALID.
- Misaligned target: if the retire takes pc_target and pc_target[1:0] != 0:
  - pc <= {pc_target[XLEN-1:2], 2'b00} and misalign_err <= 1.
  - misalign_err stays set until reset.
- op and pc_plus4 are combinational from instr and pc.
- Reset mid-operation (WAIT or VALID):
  - All state returns to reset values at that edge.
  - An ack arriving in the same cycle as active reset is discarded.
  - The first post-reset request is to RESET_PC.

Test Plan:
- Reset, zero-wait memory returning 7'd3 (lw), then 7'd35 (sw), then 7'd99 (beq) at 0, 4, 8; instr_ready tied 1 -> op sequence 3, 35, 99; pc 0, 4, 8; instret = 3 after the third retire; instr_valid toggles every other cycle.
- Memory acks 3 cycles after the request -> imem_req high and imem_addr stable for 3 cycles; instr_valid one cycle after ack.
- In VALID at pc = 8, hold instr_ready low 5 cycles, then pulse it with pc_src = 1, pc_target = 32'h40 -> outputs unchanged while stalled; next imem_addr = 32'h40.
- Retire with pc_src = 1, pc_target = 32'h22 -> pc = 32'h20, misalign_err = 1; it stays 1 after further normal retires.
- RESET_PC = 32'hFFFF_FFFC, retire with pc_src = 0 -> pc wraps to 0; instret preloaded through 2^32-1 retires, or forced, wraps to 0.
- Assert rst_n = 0 during WAIT with imem_ack = 1 in the same cycle -> instr_valid stays 0; next request is to RESET_PC; instret = 0.
